// File: rtl/rgb_led_pwm.sv
// Multi-channel LED PWM: prescaled 8-bit counter, double-buffered duty registers
// (shadow written any time, active loaded at the period boundary), registered outputs.
module rgb_led_pwm #(
  parameter int unsigned NumChannels = 12,
  parameter int unsigned PrescaleDiv = 64,
  parameter logic [7:0]  DefaultDuty = 8'd32
) (
  input  logic                   clk_sys_i,
  input  logic                   rst_sys_ni,
  input  logic [NumChannels-1:0] en_i,
  input  logic                   wr_en_i,
  input  logic [3:0]             wr_addr_i,
  input  logic [7:0]             wr_data_i,
  output logic [NumChannels-1:0] pwm_o,
  output logic                   period_start_o
);

  localparam logic [15:0] PresLast = 16'(PrescaleDiv - 1);

  logic [15:0]            presc_q;
  logic                   tick;
  logic [7:0]             pwm_cnt_q;
  logic                   wrap;
  logic                   wrap_q;
  logic [7:0]             shadow_duty [NumChannels];
  logic [7:0]             active_duty [NumChannels];
  logic [NumChannels-1:0] pwm_d;

  always_comb begin
    tick = (presc_q == PresLast);
    wrap = tick && (pwm_cnt_q == 8'hFF);
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      presc_q   <= '0;
      pwm_cnt_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      presc_q   <= tick ? '0 : presc_q + 16'd1;
      pwm_cnt_q <= tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
      wrap_q    <= wrap;
    end
  end

  // Active load samples the shadow before this edge's write lands, so a write
  // coincident with the wrap takes effect one period later.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        shadow_duty[i] <= DefaultDuty;
        active_duty[i] <= DefaultDuty;
      end
    end else begin
      for (int unsigned i = 0; i < NumChannels; i++) begin
        if (wr_en_i && (wr_addr_i == 4'(i))) shadow_duty[i] <= wr_data_i;
        if (wrap) active_duty[i] <= shadow_duty[i];
      end
    end
  end

  always_comb begin
    pwm_d = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      pwm_d[i] = en_i[i] && (pwm_cnt_q < active_duty[i]);
    end
  end

  // Start pulse is delayed one clock so it lines up with the first output
  // cycle that reflects counter 0 of the new period.
  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      pwm_o          <= '0;
      period_start_o <= 1'b0;
    end else begin
      pwm_o          <= pwm_d;
      period_start_o <= wrap_q;
    end
  end

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Randomized bench for rgb_led_pwm: a time-indexed reference model predicts
// every output cycle of pwm_o and period_start_o.
module tb_rgb_led_pwm;
  localparam int unsigned NCH  = 12;
  localparam int unsigned PDIV = 4;
  localparam int unsigned PERIOD = 256 * PDIV;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [NCH-1:0] en = '0;
  logic           wr_en = 1'b0;
  logic [3:0]     wr_addr = '0;
  logic [7:0]     wr_data = '0;
  logic [NCH-1:0] pwm;
  logic           ps;

  rgb_led_pwm #(.NumChannels(NCH), .PrescaleDiv(PDIV), .DefaultDuty(8'd32)) dut (
    .clk_sys_i(clk), .rst_sys_ni(rst_n), .en_i(en), .wr_en_i(wr_en),
    .wr_addr_i(wr_addr), .wr_data_i(wr_data), .pwm_o(pwm), .period_start_o(ps)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: t = number of rising edges since reset release.
  int unsigned    t;
  int unsigned    m_shadow [NCH];
  int unsigned    m_active [NCH];
  logic [NCH-1:0] en_prev;
  logic           wr_prev;
  int unsigned    addr_prev;
  int unsigned    data_prev;

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < NCH; i++) begin
      m_shadow[i] = 32;
      m_active[i] = 32;
    end
  endtask

  task automatic model_edge_and_check();
    int unsigned    cnt_before;
    logic [NCH-1:0] exp_pwm;
    logic           exp_ps;
    t++;
    cnt_before = ((t - 1) / PDIV) % 256;
    for (int i = 0; i < NCH; i++) exp_pwm[i] = en_prev[i] && (cnt_before < m_active[i]);
    exp_ps = (t > 1) && (((t - 1) % PERIOD) == 0);
    if ((t % PERIOD) == 0) begin
      for (int i = 0; i < NCH; i++) m_active[i] = m_shadow[i];
    end
    if (wr_prev && addr_prev < NCH) m_shadow[addr_prev] = data_prev;
    check($sformatf("pwm@%0d", t), 32'(pwm), 32'(exp_pwm));
    check($sformatf("ps@%0d", t), 32'(ps), 32'(exp_ps));
  endtask

  task automatic drive_random();
    int unsigned sel;
    if ($urandom_range(0, 31) == 0) en[$urandom_range(0, NCH - 1)] ^= 1'b1;
    wr_en = 1'b0;
    // Bias writes onto the edge that reloads active duty.
    if ((((t + 1) % PERIOD) == 0) || ($urandom_range(0, 47) == 0)) begin
      wr_en   = 1'b1;
      wr_addr = 4'($urandom_range(0, 15));
      sel     = $urandom_range(0, 3);
      wr_data = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom_range(0, 255));
    end
    en_prev   = en;
    wr_prev   = wr_en;
    addr_prev = 32'(wr_addr);
    data_prev = 32'(wr_data);
  endtask

  task automatic run_cycles(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      model_edge_and_check();
      drive_random();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_pwm", 32'(pwm), 32'd0);
    check("reset_ps", 32'(ps), 32'd0);
    model_reset();
    en = '1;
    en_prev = en;
    wr_prev = 1'b0;
    addr_prev = 0;
    data_prev = 0;
    rst_n = 1'b1;

    run_cycles(2 * PERIOD + 400);

    // Asynchronous reset in the middle of a period.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_ps", 32'(ps), 32'd0);
    wr_en = 1'b0;
    en = '1;
    repeat (2) @(negedge clk);
    check("held_rst_pwm", 32'(pwm), 32'd0);
    model_reset();
    en_prev = en;
    wr_prev = 1'b0;
    rst_n = 1'b1;

    run_cycles(2 * PERIOD + 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
